// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one shared DRAM line port for the core's instruction-read
// and data-read/write line requests. One request is in flight at a time. The
// requester gets a single-cycle valid pulse when its line is done. If the DRAM
// never answers, a timeout ends the transaction and raises a sticky error flag.

module mem_port_arbiter #(
    parameter  int BYTE_OFF_BITS  = 5,
    parameter  int TIMEOUT_CYCLES = 64,
    localparam int LINE_SIZE      = 8 * (2 ** BYTE_OFF_BITS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 instr_read_enable_i,
    input  logic [31:0]          instr_addr_i,
    output logic                 instr_read_valid_o,
    output logic [LINE_SIZE-1:0] instr_read_data_o,

    input  logic                 data_read_enable_i,
    input  logic                 data_write_enable_i,
    input  logic [31:0]          data_addr_i,
    input  logic [LINE_SIZE-1:0] data_write_data_i,
    output logic                 data_read_valid_o,
    output logic                 data_write_valid_o,
    output logic [LINE_SIZE-1:0] data_read_data_o,

    output logic [31:0]          dram_addr_o,
    output logic                 dram_read_enable_o,
    output logic                 dram_write_enable_o,
    output logic [LINE_SIZE-1:0] dram_data_o,
    input  logic                 dram_read_valid_i,
    input  logic                 dram_write_valid_i,
    input  logic [LINE_SIZE-1:0] dram_data_i,

    output logic                 error_o
);

    // The counter only has to reach TIMEOUT_CYCLES-1: the timeout fires on the
    // edge that would have taken it to TIMEOUT_CYCLES.
    localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INSTR_RD,
        ST_DATA_RD,
        ST_DATA_WR,
        ST_RESP
    } state_e;

    typedef enum logic {
        PORT_INSTR,
        PORT_DATA
    } port_e;

    // Control state
    state_e           state_q, state_d;
    port_e            last_grant_q, last_grant_d;
    logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;
    logic             error_q, error_d;

    // Registered outputs
    logic [31:0]          dram_addr_q, dram_addr_d;
    logic                 dram_read_en_q, dram_read_en_d;
    logic                 dram_write_en_q, dram_write_en_d;
    logic [LINE_SIZE-1:0] dram_data_q, dram_data_d;
    logic                 instr_valid_q, instr_valid_d;
    logic [LINE_SIZE-1:0] instr_data_q, instr_data_d;
    logic                 data_rd_valid_q, data_rd_valid_d;
    logic                 data_wr_valid_q, data_wr_valid_d;
    logic [LINE_SIZE-1:0] data_rd_data_q, data_rd_data_d;

    // Arbitration and completion decode
    logic data_pending;
    logic contested;
    logic grant_instr;
    logic grant_data;
    logic busy;
    logic dram_done;
    logic timed_out;
    logic finish;

    // Pick a winner for IDLE. A contested grant goes to the port that did not
    // win the last contested grant. An uncontested grant leaves that history
    // alone, so back-to-back ties alternate cleanly.
    always_comb begin
        data_pending = data_read_enable_i | data_write_enable_i;
        contested    = instr_read_enable_i & data_pending;
        grant_instr  = 1'b0;
        grant_data   = 1'b0;
        if (contested) begin
            if (last_grant_q == PORT_DATA) begin
                grant_instr = 1'b1;
            end else begin
                grant_data = 1'b1;
            end
        end else begin
            grant_instr = instr_read_enable_i;
            grant_data  = data_pending;
        end
    end

    // Decide whether the transaction in flight ends this cycle. A DRAM answer
    // takes priority over a timeout that lands on the same edge. A valid of
    // the wrong kind does not count.
    always_comb begin
        busy      = 1'b0;
        dram_done = 1'b0;
        case (state_q)
            ST_INSTR_RD, ST_DATA_RD: begin
                busy      = 1'b1;
                dram_done = dram_read_valid_i;
            end
            ST_DATA_WR: begin
                busy      = 1'b1;
                dram_done = dram_write_valid_i;
            end
            default: begin
                busy      = 1'b0;
                dram_done = 1'b0;
            end
        endcase
        timed_out = busy & ~dram_done & (timeout_cnt_q == CNT_LAST);
        finish    = dram_done | timed_out;
    end

    // State register: control flops, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= PORT_DATA;
            timeout_cnt_q <= '0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            timeout_cnt_q <= timeout_cnt_d;
            error_q       <= error_d;
        end
    end

    // Next-state logic: grant from IDLE, wait in a busy state, then one RESP
    // cycle so the requester can drop its enable before requests are sampled.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        timeout_cnt_d = timeout_cnt_q;
        error_d       = error_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_instr) begin
                    state_d       = ST_INSTR_RD;
                    timeout_cnt_d = '0;
                    if (contested) begin
                        last_grant_d = PORT_INSTR;
                    end
                end else if (grant_data) begin
                    state_d       = data_write_enable_i ? ST_DATA_WR : ST_DATA_RD;
                    timeout_cnt_d = '0;
                    if (contested) begin
                        last_grant_d = PORT_DATA;
                    end
                end
            end
            ST_INSTR_RD, ST_DATA_RD, ST_DATA_WR: begin
                if (finish) begin
                    state_d = ST_RESP;
                    error_d = error_q | timed_out;
                end else begin
                    timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: drive the DRAM on grant and hold it while busy. On
    // completion, drop the DRAM and pulse the owner's valid. Only a real DRAM
    // read answer updates the owner's line register; a timeout or a write
    // leaves it alone.
    always_comb begin
        dram_addr_d     = dram_addr_q;
        dram_read_en_d  = dram_read_en_q;
        dram_write_en_d = dram_write_en_q;
        dram_data_d     = dram_data_q;
        instr_valid_d   = 1'b0;
        instr_data_d    = instr_data_q;
        data_rd_valid_d = 1'b0;
        data_wr_valid_d = 1'b0;
        data_rd_data_d  = data_rd_data_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_instr) begin
                    dram_addr_d    = instr_addr_i;
                    dram_read_en_d = 1'b1;
                end else if (grant_data) begin
                    dram_addr_d = data_addr_i;
                    if (data_write_enable_i) begin
                        dram_write_en_d = 1'b1;
                        dram_data_d     = data_write_data_i;
                    end else begin
                        dram_read_en_d = 1'b1;
                    end
                end
            end
            ST_INSTR_RD: begin
                if (finish) begin
                    dram_read_en_d = 1'b0;
                    instr_valid_d  = 1'b1;
                    if (dram_done) begin
                        instr_data_d = dram_data_i;
                    end
                end
            end
            ST_DATA_RD: begin
                if (finish) begin
                    dram_read_en_d  = 1'b0;
                    data_rd_valid_d = 1'b1;
                    if (dram_done) begin
                        data_rd_data_d = dram_data_i;
                    end
                end
            end
            ST_DATA_WR: begin
                if (finish) begin
                    dram_write_en_d = 1'b0;
                    data_wr_valid_d = 1'b1;
                end
            end
            default: begin
                dram_read_en_d  = dram_read_en_q;
                dram_write_en_d = dram_write_en_q;
            end
        endcase
    end

    // Output registers: cleared asynchronously so the DRAM enables drop the
    // moment reset is asserted and no stale valid can escape.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dram_addr_q     <= '0;
            dram_read_en_q  <= 1'b0;
            dram_write_en_q <= 1'b0;
            dram_data_q     <= '0;
            instr_valid_q   <= 1'b0;
            instr_data_q    <= '0;
            data_rd_valid_q <= 1'b0;
            data_wr_valid_q <= 1'b0;
            data_rd_data_q  <= '0;
        end else begin
            dram_addr_q     <= dram_addr_d;
            dram_read_en_q  <= dram_read_en_d;
            dram_write_en_q <= dram_write_en_d;
            dram_data_q     <= dram_data_d;
            instr_valid_q   <= instr_valid_d;
            instr_data_q    <= instr_data_d;
            data_rd_valid_q <= data_rd_valid_d;
            data_wr_valid_q <= data_wr_valid_d;
            data_rd_data_q  <= data_rd_data_d;
        end
    end

    assign instr_read_valid_o  = instr_valid_q;
    assign instr_read_data_o   = instr_data_q;
    assign data_read_valid_o   = data_rd_valid_q;
    assign data_write_valid_o  = data_wr_valid_q;
    assign data_read_data_o    = data_rd_data_q;
    assign dram_addr_o         = dram_addr_q;
    assign dram_read_enable_o  = dram_read_en_q;
    assign dram_write_enable_o = dram_write_en_q;
    assign dram_data_o         = dram_data_q;
    assign error_o             = error_q;

endmodule
